fifo_umbrales: RTL and testbench

//  Parametrised synchronous FIFO: next generation of the team's fifo block.

---
 rtl/fifo_umbrales_pkg.sv | 21 ++
 rtl/fifo_umbrales_mem.sv | 38 +++
 rtl/fifo_umbrales.sv | 153 +++++++++++++++
 tb/tb_fifo_umbrales.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbrales_pkg.sv
// -----------------------------------------------------------------------------
// fifo_umbrales_pkg
// Shared constants for the thresholded FIFO (fifo_umbrales) and its memory.
//   DW_DEF / AW_DEF : default data width and address width (depth = 2**AW)
//   OP_*            : {write_accepted, read_accepted} codes used by the
//                     occupancy counter update
// The optional first-word-fall-through mode is selected by defining the
// FIFO_FWFT_EN macro at compile time; see fifo_umbrales.sv.
// -----------------------------------------------------------------------------
package fifo_umbrales_pkg;

    localparam int DW_DEF = 10;
    localparam int AW_DEF = 3;

    // {wr_acc, rd_acc}
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_BOTH  = 2'b11;

endpackage

// File: rtl/fifo_umbrales_mem.sv
// -----------------------------------------------------------------------------
// fifo_umbrales_mem
// 2**AW x DW register array: synchronous write, asynchronous read.
// Read registering is done by the parent so that both output modes share
// the same storage. Contents are not reset.
// Ports:
//   clk_i     clock
//   we_i      write strobe (already qualified by the parent)
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address
//   rdata_o   combinational read data at raddr_i
// -----------------------------------------------------------------------------
module fifo_umbrales_mem
    import fifo_umbrales_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_umbrales.sv
// -----------------------------------------------------------------------------
// fifo_umbrales
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// occupancy output, read-valid strobe and a sticky overflow/underflow flag.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through output mode;
// when undefined the output is a registered read with 1-cycle latency.
// Parameters:
//   tamano_datos    data width (DW)
//   tamano_direcion address width (AW), depth = 2**AW
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   write_enable  push request
//   read_enable   pop request (acknowledge of presented word in FWFT mode)
//   data_in       push data
//   umbral_alto   almost_full threshold  (almost_full  = contador >= umbral_alto)
//   umbral_bajo   almost_empty threshold (almost_empty = contador <= umbral_bajo)
//   data_out      popped / presented word
//   valid         data_out carries a word
//   full, empty   occupancy == depth / == 0
//   almost_full, almost_empty  threshold flags (combinational)
//   error         sticky overflow/underflow flag, cleared only by reset
//   contador      occupancy 0..depth
// Handshake: a pop is accepted when read_enable & !empty; a push is accepted
// when write_enable & (!full | pop accepted). Requests that are not accepted
// are dropped and raise error.
// -----------------------------------------------------------------------------
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int tamano_datos    = DW_DEF,
    parameter int tamano_direcion = AW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_enable,
    input  logic                      read_enable,
    input  logic [tamano_datos-1:0]   data_in,
    input  logic [tamano_direcion:0]  umbral_alto,
    input  logic [tamano_direcion:0]  umbral_bajo,
    output logic [tamano_datos-1:0]   data_out,
    output logic                      valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      error,
    output logic [tamano_direcion:0]  contador
);

    localparam int DW = tamano_datos;
    localparam int AW = tamano_direcion;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          error_q, error_d;
    logic          rd_acc, wr_acc;
    logic          overflow, underflow;
    logic [DW-1:0] mem_rdata;

    // Flags straight from the counter so threshold changes show immediately.
    assign full         = (cnt_q == DEPTH);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= umbral_alto);
    assign almost_empty = (cnt_q <= umbral_bajo);
    assign contador     = cnt_q;
    assign error        = error_q;

    assign rd_acc    = read_enable & ~empty;
    assign wr_acc    = write_enable & (~full | rd_acc);
    assign overflow  = write_enable & full & ~rd_acc;
    assign underflow = read_enable & empty;

    // At full with a simultaneous pop, wr_ptr == rd_ptr; the asynchronous read
    // sees the pre-edge word while the write lands at the edge, so the pop
    // returns the old contents (read-before-write).
    fifo_umbrales_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        error_d  = error_q | overflow | underflow;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            OP_WRITE: cnt_d = cnt_q + 1'b1;
            OP_READ:  cnt_d = cnt_q - 1'b1;
            default:  cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of the queue is presented whenever the FIFO holds data.
    assign valid    = ~empty;
    assign data_out = valid ? mem_rdata : '0;
`else
    logic [DW-1:0] data_out_q, data_out_d;
    logic          valid_q, valid_d;

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = rd_acc;
        if (rd_acc) begin
            data_out_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
`endif

endmodule

// File: tb/tb_fifo_umbrales.sv
module tb_fifo_umbrales;

    localparam int DW = 10;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          write_enable;
    logic          read_enable;
    logic [DW-1:0] data_in;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [AW:0]   contador;

    int n_cmp = 0;
    int n_err = 0;

    fifo_umbrales #(
        .tamano_datos    (DW),
        .tamano_direcion (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_in      (data_in),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid        (valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .contador     (contador)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given requests; outputs sampled 1 time unit
    // after the rising edge, requests deasserted afterwards.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
        write_enable = we;
        read_enable  = re;
        data_in      = din;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] din);
        cycle(1'b1, 1'b0, din);
    endtask

    // Pop one word and check it against the expected value.
    task automatic pop_check(input string tag, input logic [DW-1:0] exp);
`ifdef FIFO_FWFT_EN
        check({tag, "_valid"}, valid, 1);
        check({tag, "_data"}, data_out, exp);
        cycle(1'b0, 1'b1, '0);
`else
        cycle(1'b0, 1'b1, '0);
        check({tag, "_valid"}, valid, 1);
        check({tag, "_data"}, data_out, exp);
`endif
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_in      = '0;
        umbral_alto  = 4'd8;
        umbral_bajo  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_cnt", contador, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data_out, 0);
        check("rst_error", error, 0);
        reset = 1'b1;

        // 1. Three writes, then asynchronous reset between edges.
        push(10'h011);
        push(10'h022);
        push(10'h033);
        check("t1_cnt3", contador, 3);
        #2 reset = 1'b0;
        #1;
        check("t1_async_empty", empty, 1);
        check("t1_async_cnt", contador, 0);
        check("t1_async_valid", valid, 0);
        check("t1_async_data", data_out, 0);
        check("t1_async_error", error, 0);
        #1 reset = 1'b1;
        cycle(1'b0, 1'b1, '0);
        check("t1_underflow_err", error, 1);
        check("t1_underflow_cnt", contador, 0);
        check("t1_underflow_valid", valid, 0);
        pulse_reset();
        check("t1_err_cleared", error, 0);

        // 2. Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) push(10'(i));
        check("t2_full", full, 1);
        check("t2_cnt8", contador, 8);
        check("t2_no_err", error, 0);
        push(10'h0AA);
        check("t2_ovf_err", error, 1);
        check("t2_ovf_cnt", contador, 8);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("t2_pop%0d", i), 10'(i));
        check("t2_empty", empty, 1);
        cycle(1'b0, 1'b0, '0);
        check("t2_idle_valid", valid, 0);
`ifdef FIFO_FWFT_EN
        check("t2_idle_data", data_out, 0);
`else
        check("t2_idle_hold", data_out, 10'h008);
`endif
        pulse_reset();

        // 3. Underflow with simultaneous write.
        cycle(1'b1, 1'b1, 10'h07F);
        check("t3_err", error, 1);
        check("t3_cnt", contador, 1);
`ifndef FIFO_FWFT_EN
        check("t3_valid", valid, 0);
`endif
        pop_check("t3_pop", 10'h07F);
        pulse_reset();

        // 4. Simultaneous read and write at full.
        for (int i = 1; i <= 8; i++) push(10'(i));
`ifdef FIFO_FWFT_EN
        check("t4_rw_data", data_out, 10'h001);
        cycle(1'b1, 1'b1, 10'h3FF);
`else
        cycle(1'b1, 1'b1, 10'h3FF);
        check("t4_rw_data", data_out, 10'h001);
        check("t4_rw_valid", valid, 1);
`endif
        check("t4_rw_cnt", contador, 8);
        check("t4_rw_err", error, 0);
        check("t4_rw_full", full, 1);
        for (int i = 2; i <= 8; i++) pop_check($sformatf("t4_pop%0d", i), 10'(i));
        pop_check("t4_pop_3ff", 10'h3FF);
        pulse_reset();

        // 5. Threshold flags.
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        #1;
        check("t5_ae_at0", almost_empty, 1);
        check("t5_af_at0", almost_full, 0);
        for (int n = 1; n <= 6; n++) begin
            push(10'(n + 16));
            check($sformatf("t5_af_n%0d", n), almost_full, (n >= 6) ? 1 : 0);
            check($sformatf("t5_ae_n%0d", n), almost_empty, (n <= 2) ? 1 : 0);
        end
        umbral_alto = 4'd7;
        #1;
        check("t5_af_thr7", almost_full, 0);
        umbral_alto = 4'd5;
        #1;
        check("t5_af_thr5", almost_full, 1);
        umbral_bajo = 4'd6;
        #1;
        check("t5_ae_thr6", almost_empty, 1);
        pulse_reset();

`ifdef FIFO_FWFT_EN
        // 6. First-word-fall-through presentation.
        push(10'h155);
        check("t6_valid", valid, 1);
        check("t6_data", data_out, 10'h155);
        cycle(1'b0, 1'b0, '0);
        check("t6_hold_data", data_out, 10'h155);
        cycle(1'b0, 1'b1, '0);
        check("t6_pop_empty", empty, 1);
        check("t6_pop_valid", valid, 0);
        check("t6_pop_data", data_out, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
